aes_result_checker: RTL and testbench

Downstream self-check stage for the SPI AES master.
- Captures the master's 128-bit `data_out` when the encrypt pass completes and again when the decrypt pass completes.
- Verifies that the decrypt result equals the plaintext that was sent.
- For the FIPS-197 Appendix C plaintext, also checks the ciphertext against the known answer for the selected key size.
- Reports pass/fail per round trip and keeps saturating pass/error counters for board-level bring-up.

---
 rtl/aes_result_checker.sv | 171 +++++++++++++++++
 tb/tb_aes_result_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_checker.sv
// Round-trip self-check for the SPI AES master: captures encrypt/decrypt results and checks them.
// Result is registered one cycle after the decrypt rise. Strobes are edge-detected, so no backpressure is needed.
module aes_result_checker #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         Nk_val,
    input  logic [127:0]       data_in,
    input  logic               done_enc,
    input  logic               done_dec,
    input  logic [127:0]       data_out,
    output logic [127:0]       cipher_q,
    output logic [127:0]       plain_q,
    output logic               result_valid,
    output logic               pass,
    output logic               fail,
    output logic               kat_hit,
    output logic               seq_err,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] KAT_CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DEC = 2'd1,
        CHECK    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               enc_prev_q, enc_prev_d;
    logic               dec_prev_q, dec_prev_d;
    logic [127:0]       cipher_d, plain_d;
    logic [127:0]       dec_q, dec_d;
    logic [1:0]         nk_q, nk_d;
    logic               result_valid_q, result_valid_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               kat_hit_q, kat_hit_d;
    logic               seq_err_q, seq_err_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               enc_rise, dec_rise;
    logic               check_now, match, kat, chk_pass;
    logic [127:0]       exp_ct;
    logic               pass_inc, err_inc;

    always_comb begin
        state_d        = state_q;
        enc_prev_d     = done_enc;
        dec_prev_d     = done_dec;
        cipher_d       = cipher_q;
        plain_d        = plain_q;
        dec_d          = dec_q;
        nk_d           = nk_q;
        result_valid_d = 1'b0;
        pass_d         = pass_q;
        fail_d         = fail_q;
        kat_hit_d      = kat_hit_q;
        seq_err_d      = 1'b0;

        enc_rise  = done_enc & ~enc_prev_q;
        dec_rise  = done_dec & ~dec_prev_q;
        check_now = (state_q == CHECK);

        case (nk_q)
            2'b00:   exp_ct = KAT_CT4;
            2'b01:   exp_ct = KAT_CT6;
            default: exp_ct = KAT_CT8;
        endcase
        match    = (dec_q == plain_q);
        kat      = (plain_q == KAT_PT);
        chk_pass = match & (~kat | (cipher_q == exp_ct));

        case (state_q)
            WAIT_DEC: begin
                // A repeated encrypt restarts the round trip with fresh captures.
                if (enc_rise) begin
                    cipher_d  = data_out;
                    plain_d   = data_in;
                    nk_d      = Nk_val;
                    seq_err_d = 1'b1;
                end else if (dec_rise) begin
                    dec_d   = data_out;
                    state_d = CHECK;
                end
            end
            default: begin
                // CHECK behaves like IDLE for new strobes so nothing is lost.
                state_d = IDLE;
                if (enc_rise) begin
                    cipher_d = data_out;
                    plain_d  = data_in;
                    nk_d     = Nk_val;
                    state_d  = WAIT_DEC;
                end else if (dec_rise) begin
                    seq_err_d = 1'b1;
                end
            end
        endcase

        if (check_now) begin
            result_valid_d = 1'b1;
            pass_d         = chk_pass;
            fail_d         = ~chk_pass;
            kat_hit_d      = kat;
        end

        // A sequence error and a failed check in one cycle count as a single error.
        pass_inc = check_now & chk_pass;
        err_inc  = seq_err_d | (check_now & ~chk_pass);

        pass_cnt_d = pass_cnt_q;
        if (pass_inc && (pass_cnt_q != {CNT_W{1'b1}})) begin
            pass_cnt_d = pass_cnt_q + 1'b1;
        end
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            enc_prev_q     <= 1'b0;
            dec_prev_q     <= 1'b0;
            cipher_q       <= '0;
            plain_q        <= '0;
            dec_q          <= '0;
            nk_q           <= '0;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            kat_hit_q      <= 1'b0;
            seq_err_q      <= 1'b0;
            pass_cnt_q     <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            enc_prev_q     <= enc_prev_d;
            dec_prev_q     <= dec_prev_d;
            cipher_q       <= cipher_d;
            plain_q        <= plain_d;
            dec_q          <= dec_d;
            nk_q           <= nk_d;
            result_valid_q <= result_valid_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            kat_hit_q      <= kat_hit_d;
            seq_err_q      <= seq_err_d;
            pass_cnt_q     <= pass_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign result_valid = result_valid_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign kat_hit      = kat_hit_q;
    assign seq_err      = seq_err_q;
    assign pass_cnt     = pass_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_aes_result_checker.sv
// Directed bench for aes_result_checker; a second CNT_W=2 instance shares the stimulus for saturation.
module tb_aes_result_checker;

    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_A5   = {16{8'ha5}};
    localparam logic [127:0] CT_X    = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] CT_Y    = 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   Nk_val = 2'b00;
    logic [127:0] data_in = '0;
    logic         done_enc = 1'b0;
    logic         done_dec = 1'b0;
    logic [127:0] data_out = '0;

    logic [127:0] cipher_q, plain_q;
    logic         result_valid, pass, fail, kat_hit, seq_err;
    logic [7:0]   pass_cnt, err_cnt;

    logic [127:0] s_cipher_q, s_plain_q;
    logic         s_result_valid, s_pass, s_fail, s_kat_hit, s_seq_err;
    logic [1:0]   s_pass_cnt, s_err_cnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_result_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .Nk_val(Nk_val), .data_in(data_in),
        .done_enc(done_enc), .done_dec(done_dec), .data_out(data_out),
        .cipher_q(cipher_q), .plain_q(plain_q), .result_valid(result_valid),
        .pass(pass), .fail(fail), .kat_hit(kat_hit), .seq_err(seq_err),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt)
    );

    aes_result_checker #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .Nk_val(Nk_val), .data_in(data_in),
        .done_enc(done_enc), .done_dec(done_dec), .data_out(data_out),
        .cipher_q(s_cipher_q), .plain_q(s_plain_q), .result_valid(s_result_valid),
        .pass(s_pass), .fail(s_fail), .kat_hit(s_kat_hit), .seq_err(s_seq_err),
        .pass_cnt(s_pass_cnt), .err_cnt(s_err_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enc(input logic [127:0] ct);
        data_out = ct;
        done_enc = 1'b1;
        tick();
        done_enc = 1'b0;
        tick();
    endtask

    // Decrypt strobe followed by the registered result one edge later.
    task automatic pulse_dec_check(input string tag, input logic [127:0] dt,
                                   input logic exp_pass, input logic exp_kat);
        data_out = dt;
        done_dec = 1'b1;
        tick();
        done_dec = 1'b0;
        chk({tag, "_rv_early"}, 128'(result_valid), 128'(1'b0));
        tick();
        chk({tag, "_rv"},   128'(result_valid), 128'(1'b1));
        chk({tag, "_pass"}, 128'(pass),         128'(exp_pass));
        chk({tag, "_fail"}, 128'(fail),         128'(!exp_pass));
        chk({tag, "_kat"},  128'(kat_hit),      128'(exp_kat));
        tick();
        chk({tag, "_rv_off"}, 128'(result_valid), 128'(1'b0));
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_cipher", cipher_q, '0);
        chk("rst_pass", 128'(pass), '0);
        chk("rst_cnt", 128'({pass_cnt, err_cnt}), '0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();

        // Nk4 known answer
        Nk_val  = 2'b00;
        data_in = KAT_PT;
        pulse_enc(KAT_CT4);
        chk("nk4_cipher", cipher_q, KAT_CT4);
        chk("nk4_plain", plain_q, KAT_PT);
        pulse_dec_check("nk4", KAT_PT, 1'b1, 1'b1);
        chk("nk4_pcnt", 128'(pass_cnt), 128'd1);
        chk("nk4_ecnt", 128'(err_cnt), 128'd0);

        // Nk6 with the Nk4 ciphertext
        Nk_val = 2'b01;
        pulse_enc(KAT_CT4);
        pulse_dec_check("nk6_bad", KAT_PT, 1'b0, 1'b1);
        chk("nk6_ecnt", 128'(err_cnt), 128'd1);

        // Non-KAT plaintext, one decrypt bit flipped then exact
        data_in = PT_A5;
        pulse_enc(CT_X);
        pulse_dec_check("a5_flip", PT_A5 ^ 128'h1, 1'b0, 1'b0);
        chk("a5_flip_ecnt", 128'(err_cnt), 128'd2);
        pulse_enc(CT_X);
        pulse_dec_check("a5_ok", PT_A5, 1'b1, 1'b0);
        chk("a5_ok_pcnt", 128'(pass_cnt), 128'd2);

        // Decrypt strobe in IDLE, twice: stays in IDLE
        for (int i = 0; i < 2; i++) begin
            data_out = PT_A5;
            done_dec = 1'b1;
            tick();
            done_dec = 1'b0;
            chk("idle_dec_seq", 128'(seq_err), 128'd1);
            tick();
            chk("idle_dec_seq_off", 128'(seq_err), 128'd0);
            chk("idle_dec_rv", 128'(result_valid), 128'd0);
        end
        chk("idle_dec_ecnt", 128'(err_cnt), 128'd4);

        // Back-to-back encrypt rises
        pulse_enc(CT_X);
        data_out = CT_Y;
        done_enc = 1'b1;
        tick();
        done_enc = 1'b0;
        chk("enc2_seq", 128'(seq_err), 128'd1);
        chk("enc2_cipher", cipher_q, CT_Y);
        chk("enc2_ecnt", 128'(err_cnt), 128'd5);
        tick();
        chk("enc2_seq_off", 128'(seq_err), 128'd0);
        pulse_dec_check("enc2_dec", PT_A5, 1'b1, 1'b0);
        chk("enc2_pcnt", 128'(pass_cnt), 128'd3);

        // Simultaneous rises in IDLE: encrypt wins silently
        data_out = CT_X;
        done_enc = 1'b1;
        done_dec = 1'b1;
        tick();
        done_enc = 1'b0;
        done_dec = 1'b0;
        chk("sim_seq", 128'(seq_err), 128'd0);
        chk("sim_cipher", cipher_q, CT_X);
        tick();
        pulse_dec_check("sim_dec", PT_A5, 1'b1, 1'b0);
        chk("sim_pcnt", 128'(pass_cnt), 128'd4);
        chk("sim_ecnt", 128'(err_cnt), 128'd5);

        // Long encrypt strobe: single capture, no sequence error
        done_enc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_out = (i == 0) ? CT_Y : {4{$urandom}};
            tick();
            chk("long_seq", 128'(seq_err), 128'd0);
        end
        done_enc = 1'b0;
        tick();
        chk("long_cipher", cipher_q, CT_Y);
        pulse_dec_check("long_dec", PT_A5, 1'b1, 1'b0);
        chk("long_pcnt", 128'(pass_cnt), 128'd5);

        // Encrypt rise landing in CHECK starts the next round trip
        pulse_enc(CT_X);
        data_out = PT_A5;
        done_dec = 1'b1;
        tick();
        done_dec = 1'b0;
        data_out = CT_Y;
        done_enc = 1'b1;
        tick();
        done_enc = 1'b0;
        chk("chk_enc_rv", 128'(result_valid), 128'd1);
        chk("chk_enc_pass", 128'(pass), 128'd1);
        chk("chk_enc_seq", 128'(seq_err), 128'd0);
        chk("chk_enc_cipher", cipher_q, CT_Y);
        tick();
        pulse_dec_check("chk_enc_dec", PT_A5, 1'b1, 1'b0);
        chk("chk_enc_pcnt", 128'(pass_cnt), 128'd7);

        // Reset in WAIT_DEC clears everything immediately
        pulse_enc(CT_X);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cipher", cipher_q, '0);
        chk("arst_plain", plain_q, '0);
        chk("arst_flags", 128'({result_valid, pass, fail, kat_hit, seq_err}), '0);
        chk("arst_cnt", 128'({pass_cnt, err_cnt}), '0);
        tick();
        rst = 1'b1;
        tick();
        data_out = PT_A5;
        done_dec = 1'b1;
        tick();
        done_dec = 1'b0;
        chk("arst_dec_seq", 128'(seq_err), 128'd1);
        chk("arst_dec_ecnt", 128'(err_cnt), 128'd1);
        tick();

        // Five Nk8 KAT passes: wide counter reaches 5, narrow saturates at 3
        Nk_val  = 2'b10;
        data_in = KAT_PT;
        for (int i = 0; i < 5; i++) begin
            pulse_enc(KAT_CT8);
            pulse_dec_check("nk8", KAT_PT, 1'b1, 1'b1);
        end
        chk("sat_pcnt_w8", 128'(pass_cnt), 128'd5);
        chk("sat_pcnt_w2", 128'(s_pass_cnt), 128'd3);
        chk("sat_ecnt_w2", 128'(s_err_cnt), 128'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
